serial_add_ctrl: RTL
====================

# serial_add_ctrl

Sequencing controller that time-shares one 3-bit ripple adder slice (the existing `three_bit` adder) to perform a wide binary addition over several clock cycles. It processes one 3-bit slice per cycle and chains the carry through a register. The result is a full-width sum plus carry-out, suitable for feeding the `BCD` / `hex_7seg` display path. It sits between the switch/key front end and the shared adder datapath and owns the adder's inputs whenever a job is running.

## Interface
Parameters:
- NSLICE, default 3: number of 3-bit slices. Operand width W = 3*NSLICE; result width W+1.

Ports:
- CLOCK_50  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op_a  in  W  operand A; captured on accepted start.
- op_b  in  W  operand B; captured on accepted start.
- cin  in  1  carry-in; captured on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when result is updated.
- result  out  W+1  {carry_out, sum}; holds last completed job.
- add_x  out  3  slice of A driven to the shared adder.
- add_y  out  3  slice of B driven to the shared adder.
- add_cin  out  1  carry into the shared adder.
- add_sum  in  3  adder sum; combinational from add_x/add_y/add_cin. Wire to bits [2:0] of the adder's sum port.
- add_cout  in  1  adder carry-out.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- **Reset** (rst_n=0 at an edge):
  - State goes to IDLE.
  - busy=0, done=0, result=0.
  - Internal slice counter, operand registers and carry register are all cleared.
  - Reset wins over every other event.
- **IDLE:**
  - When start=1, latch op_a, op_b and cin into internal registers, set slice=0 and carry_reg=cin, then go to RUN.
  - When start=0, stay in IDLE.
- **RUN:**
  - add_x = a_reg[3*slice+2 : 3*slice].
  - add_y = b_reg[3*slice+2 : 3*slice].
  - add_cin = carry_reg.
  - At each edge:
    - work[3*slice+2 : 3*slice] <= add_sum.
    - carry_reg <= add_cout.
    - slice increments.
  - At the edge where slice = NSLICE-1: result <= {add_cout, work with the final slice inserted}, then go to DONE.
- **DONE:** done=1 for exactly this cycle, then unconditionally go to IDLE. start is ignored in this state.
- **Outside RUN:** add_x=0, add_y=0, add_cin=0, so the adder sees all-zero inputs.
- **start while busy or DONE:** ignored, with no queueing. start held high is re-accepted on the first IDLE cycle after DONE.
- **Operand changes after acceptance:** changes on op_a, op_b or cin have no effect on the running job.
- **Arithmetic:** result = op_a + op_b + cin, modulo 2^(W+1). The result can never overflow its W+1 bits.
- **Wrap-around:** the slice counter never exceeds NSLICE-1.
- **result stability:**
  - result changes only on the RUN→DONE edge or on reset.
  - It is stable during RUN; partial sums are never visible.

## Timing
- Let the start acceptance edge be E0.
- busy is high for cycles E0+1 through E0+NSLICE.
- result is valid and done=1 in the cycle after edge E0+NSLICE. Latency is NSLICE+1 cycles from start to done.
- Throughput: one job per NSLICE+2 cycles.
- Adder path: add_x/add_y/add_cin → add_sum/add_cout must settle within one CLOCK_50 period. This is the ripple through 3 full adders.
- Reset during RUN: the job is aborted, no done pulse is issued, and result reads 0 on the next cycle.

## Test plan
- **Basic add** (NSLICE=3, real `three_bit` adder attached): op_a=5, op_b=3, cin=0, start pulse.
  - Required: busy high for 3 cycles; done pulse on the 4th cycle after acceptance; result=10'd8.
- **Full carry chain:** op_a=511, op_b=511, cin=1.
  - Required: result=10'd1023.
  - Required: add_cin reads 1 in all three RUN cycles.
- **Inter-slice carry:** op_a=9'o007, op_b=9'o001, cin=0.
  - Required: slice-0 add_cout=1; slice-1 add_cin=1; result=10'd8.
- **start during busy:** pulse start again in RUN cycle 2 with new operands 100+100.
  - Required: exactly one done; result equals the first job only.
  - Required: busy stays low after DONE.
- **start held high:** hold start=1 continuously for two jobs with op_a=1, op_b=2.
  - Required: done every 5 cycles; result=3.
  - Required: add_x/add_y are 0 in DONE and IDLE cycles.
- **Reset mid-run:** assert rst_n=0 for one cycle during RUN cycle 2.
  - Required: busy=0 and result=0 the next cycle; no done pulse; a subsequent job runs normally.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Drives one shared 3-bit ripple adder slice over NSLICE cycles to add two
// W-bit operands (W = 3*NSLICE) plus a carry-in. The carry between slices
// is held in a register. The {carry_out, sum} result is held until the
// next job completes.
module serial_add_ctrl #(
  parameter int NSLICE = 3
) (
  input  logic                  CLOCK_50,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [3*NSLICE-1:0]   op_a,
  input  logic [3*NSLICE-1:0]   op_b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [3*NSLICE:0]     result,
  output logic [2:0]            add_x,
  output logic [2:0]            add_y,
  output logic                  add_cin,
  input  logic [2:0]            add_sum,
  input  logic                  add_cout
);

  localparam int W  = 3 * NSLICE;
  localparam int SW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [SW-1:0] LAST = SW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state, state_next;
  logic [SW-1:0] slice;
  logic [W-1:0]  a_reg, b_reg;
  logic [W-1:0]  work, work_next;
  logic          carry_reg;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Next-state logic: accept start only in IDLE, leave RUN after the last
  // slice, and spend exactly one cycle in DONE.
  always_comb begin
    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves it unassigned would infer a latch.
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (slice == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Adder input steering and merge of the current slice sum into the
  // partial result. The adder sees all-zero inputs outside RUN.
  always_comb begin
    add_x     = '0;
    add_y     = '0;
    add_cin   = 1'b0;
    work_next = work;
    if (state == RUN) begin
      add_cin = carry_reg;
      for (int i = 0; i < NSLICE; i++) begin
        if (slice == SW'(i)) begin
          add_x                = a_reg[3*i +: 3];
          add_y                = b_reg[3*i +: 3];
          work_next[3*i +: 3]  = add_sum;
        end
      end
    end
  end

  // State, operand capture, slice sequencing and result update.
  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before this edge, regardless of statement order.
    if (!rst_n) begin
      // NOTE: operand and partial-sum registers are cleared too, so an
      // aborted job leaves nothing behind that a later job could observe.
      state     <= IDLE;
      slice     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      work      <= '0;
      carry_reg <= 1'b0;
      result    <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= op_a;
            b_reg     <= op_b;
            carry_reg <= cin;
            slice     <= '0;
          end
        end
        RUN: begin
          work      <= work_next;
          carry_reg <= add_cout;
          if (slice == LAST) begin
            slice  <= '0;
            result <= {add_cout, work_next};
          end else begin
            slice <= slice + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
